// File: rtl/mem_bank_rw_client_pkg.sv
// mem_bank_pkg: shared types and constants for the bank RW-port client
package mem_bank_pkg;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_WIDTH = 64;
  localparam int RSP_FIFO_DEPTH = 2;
  typedef enum logic {INIT, RUN} state_e;
  typedef logic [$clog2(DEF_DEPTH)-1:0] addr_t;
  typedef logic [DEF_WIDTH-1:0] data_t;
endpackage

// File: rtl/mem_bank_rw_client_if.sv
// mem_bank_rw_client_if: request/response streams between a requester (master) and the client (slave)
interface mem_bank_rw_client_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  modport master (
    output req_valid, req_write, req_addr, req_wmask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wmask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_bank_rw_client_fifo.sv
// mem_rsp_fifo2: 2-entry valid/ready response FIFO
//   push/push_data in, pop_valid/pop_ready/pop_data out, count = occupancy
module mem_rsp_fifo2 import mem_bank_pkg::*; #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         pop_valid,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);
  logic [W-1:0] mem [RSP_FIFO_DEPTH];
  logic wr_ptr, rd_ptr, wr, rd;
  assign pop_valid = count != 2'd0;
  assign pop_data = mem[rd_ptr];
  assign wr = push && count < 2'(RSP_FIFO_DEPTH);
  assign rd = pop_valid && pop_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ wr;
      rd_ptr <= rd_ptr ^ rd;
      count <= count + 2'(wr) - 2'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/mem_bank_rw_client.sv
// mem_bank_rw_client: drives one RW port of a masked register bank from a request stream
//   clk/rst_n, bus (req_*/rsp_* streams), init_start/init_busy (re-init sweep),
//   RW_wmode/RW_addr/RW_wmask/RW_wdata to the bank, RW_rdata combinational read back
module mem_bank_rw_client import mem_bank_pkg::*; #(
  parameter int REG_DEPTH = 4,
  parameter int REG_WIDTH = 64,
  parameter logic [REG_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mem_bank_rw_client_if.slave          bus,
  input  logic                         init_start,
  output logic                         init_busy,
  output logic                         RW_wmode,
  output logic [$clog2(REG_DEPTH)-1:0] RW_addr,
  output logic [REG_WIDTH-1:0]         RW_wmask,
  output logic [REG_WIDTH-1:0]         RW_wdata,
  input  logic [REG_WIDTH-1:0]         RW_rdata
);
  localparam int AW = $clog2(REG_DEPTH);
  state_e state;
  logic [AW-1:0] cnt;
  logic init_pending, sweep, accept;
  logic [1:0] fifo_count;
  assign sweep = state == INIT;
  assign bus.req_ready = !sweep && !init_pending && fifo_count < 2'(RSP_FIFO_DEPTH);
  assign accept = bus.req_valid && bus.req_ready;
  assign init_busy = sweep || init_pending;
  // reset shares the INIT state, so gate the write strobe to keep the bank untouched while held
  assign RW_wmode = rst_n && (sweep || (accept && bus.req_write));
  assign RW_addr = sweep ? cnt : bus.req_addr;
  assign RW_wmask = sweep ? '1 : bus.req_wmask;
  assign RW_wdata = sweep ? INIT_VALUE : bus.req_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
      init_pending <= 1'b0;
    end else if (sweep) begin
      cnt <= cnt + 1'b1;
      if (cnt == AW'(REG_DEPTH - 1)) begin
        state <= RUN;
        cnt <= '0;
      end
    end else if (init_pending && fifo_count == 2'd0) begin
      state <= INIT;
      init_pending <= 1'b0;
    end else if (init_start) init_pending <= 1'b1;
  // read data is captured in the acceptance cycle, before any write at that edge lands
  mem_rsp_fifo2 #(.W(REG_WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept && !bus.req_write),
    .push_data (RW_rdata),
    .pop_ready (bus.rsp_ready),
    .pop_valid (bus.rsp_valid),
    .pop_data  (bus.rsp_rdata),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_mem_bank_rw_client.sv
// tb_mem_bank_rw_client: directed plus random stimulus against a bank model and a scoreboard
module tb_mem_bank_rw_client;
  import mem_bank_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_start = 1'b0;
  logic init_busy, RW_wmode, scramble;
  logic [1:0] RW_addr;
  data_t RW_wmask, RW_wdata, RW_rdata;
  data_t bank [DEPTH];
  data_t ref_mem [DEPTH];
  data_t exp_q [$];
  int m_sweep, checks, failures;
  logic m_pending;
  mem_bank_rw_client_if #(.ADDR_W(2), .DATA_W(64)) bus ();
  mem_bank_rw_client #(.REG_DEPTH(DEPTH), .REG_WIDTH(64), .INIT_VALUE('0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .init_start (init_start),
    .init_busy  (init_busy),
    .RW_wmode   (RW_wmode),
    .RW_addr    (RW_addr),
    .RW_wmask   (RW_wmask),
    .RW_wdata   (RW_wdata),
    .RW_rdata   (RW_rdata)
  );
  always #5 clk = ~clk;
  assign RW_rdata = bank[RW_addr];
  always @(posedge clk)
    if (scramble) for (int i = 0; i < DEPTH; i++) bank[i] <= {$urandom, $urandom};
    else if (RW_wmode) bank[RW_addr] <= (bank[RW_addr] & ~RW_wmask) | (RW_wdata & RW_wmask);
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    scramble = 1'b1;
    bus.req_valid = 1'b0;
    init_start = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_init_busy", 64'(init_busy), 64'd1);
    check("rst_wmode", 64'(RW_wmode), 64'd0);
    exp_q.delete();
    m_pending = 1'b0;
    m_sweep = DEPTH;
    clear_ref();
    repeat (2) @(posedge clk);
    #2;
    scramble = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic step(input logic v, input logic w, input logic [1:0] a, input data_t m, input data_t d,
                      input logic rr, input logic is);
    logic busy_m, rdy_m;
    int cur;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr = a;
    bus.req_wmask = m;
    bus.req_wdata = d;
    bus.rsp_ready = rr;
    init_start = is;
    #1;
    cur = exp_q.size();
    busy_m = m_sweep > 0 || m_pending;
    rdy_m = !busy_m && cur < 2;
    check("init_busy", 64'(init_busy), 64'(busy_m));
    check("req_ready", 64'(bus.req_ready), 64'(rdy_m));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(cur != 0));
    if (cur != 0) check("rsp_rdata", bus.rsp_rdata, exp_q[0]);
    if (m_sweep > 0) begin
      check("init_wmode", 64'(RW_wmode), 64'd1);
      check("init_addr", 64'(RW_addr), 64'(DEPTH - m_sweep));
      check("init_wmask", RW_wmask, '1);
      check("init_wdata", RW_wdata, '0);
    end else begin
      check("run_wmode", 64'(RW_wmode), 64'(v && rdy_m && w));
      check("run_addr", 64'(RW_addr), 64'(a));
    end
    if (cur != 0 && rr) void'(exp_q.pop_front());
    if (v && rdy_m) begin
      if (w) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
      else exp_q.push_back(ref_mem[a]);
    end
    if (m_sweep > 0) m_sweep--;
    else if (m_pending && cur == 0) begin
      m_pending = 1'b0;
      m_sweep = DEPTH;
      clear_ref();
    end else if (is) m_pending = 1'b1;
  endtask
  task automatic idle(input logic rr);
    step(1'b0, 1'b0, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, rr, 1'b0);
  endtask
  initial begin
    checks = 0;
    failures = 0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wmask = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    do_reset();
    repeat (4) idle(1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 2'(i), '0, '0, 1'b1, 1'b0);
    repeat (2) idle(1'b1);
    step(1'b1, 1'b1, 2'd2, 64'h0000_0000_FFFF_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd2, '0, '0, 1'b1, 1'b0);
    idle(1'b1);
    check("t2_masked_read", bus.rsp_rdata, 64'h0000_0000_FFFF_0000);
    step(1'b1, 1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd1, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd2, '0, '0, 1'b0, 1'b0);
    check("t3_third_blocked", 64'(bus.req_ready), 64'd0);
    repeat (2) step(1'b1, 1'b0, 2'd2, '0, '0, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    step(1'b1, 1'b1, 2'd1, '1, 64'hA5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd1, '0, '0, 1'b1, 1'b0);
    idle(1'b1);
    check("t4_raw", bus.rsp_rdata, 64'hA5);
    step(1'b1, 1'b0, 2'd2, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd1, '0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, '0, '0, 1'b0, 1'b1);
    idle(1'b0);
    check("t5_ready_drop", 64'(bus.req_ready), 64'd0);
    check("t5_busy", 64'(init_busy), 64'd1);
    repeat (10) idle(1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 2'(i), '0, '0, 1'b1, 1'b0);
    repeat (2) idle(1'b1);
    step(1'b0, 1'b0, 2'd0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 20 && m_sweep != 2; i++) idle(1'b1);
    check("t6_sweep_at_2", 64'(m_sweep), 64'd2);
    do_reset();
    repeat (6) idle(1'b1);
    for (int i = 0; i < 600; i++)
      step(1'($urandom), 1'($urandom), 2'($urandom),
           ($urandom % 3 == 0) ? '1 : {$urandom, $urandom}, {$urandom, $urandom},
           $urandom % 4 != 0, $urandom % 60 == 0);
    repeat (12) idle(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
